// File: rtl/plic_scalable.sv
// Platform-level interrupt controller with word-banked enable/pending state,
// per-source edge counting gateways and a registered per-target priority select.
module plic_scalable #(
    parameter int unsigned N_SOURCE   = 64,
    parameter int unsigned N_TARGET   = 2,
    parameter int unsigned MAX_PRIO   = 7,
    parameter int unsigned EDGE_CNT_W = 3,
    parameter int unsigned ADDR_W     = 24
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    input  logic                req_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [31:0]         req_wdata_i,
    output logic                rsp_valid_o,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_error_o,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic [N_SOURCE-1:0] irq_sources_i,
    output logic [N_TARGET-1:0] eip_targets_o
);

    localparam int unsigned PRIOW = $clog2(MAX_PRIO + 1);
    localparam int unsigned SRCW  = $clog2(N_SOURCE + 1);
    localparam int unsigned NWORD = (N_SOURCE + 1 + 31) / 32;
    localparam int unsigned NBIT  = NWORD * 32;
    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    // Register state
    logic [PRIOW-1:0]      prio_q [1:N_SOURCE];
    logic [PRIOW-1:0]      prio_d [1:N_SOURCE];
    logic [EDGE_CNT_W-1:0] cnt_q  [1:N_SOURCE];
    logic [EDGE_CNT_W-1:0] cnt_d  [1:N_SOURCE];
    logic [N_SOURCE:1]     inflight_q, inflight_d;
    logic [N_SOURCE-1:0]   src_q;
    logic [NBIT-1:0]       ie_q [N_TARGET];
    logic [NBIT-1:0]       ie_d [N_TARGET];
    logic [PRIOW-1:0]      thr_q [N_TARGET];
    logic [PRIOW-1:0]      thr_d [N_TARGET];
    logic [SRCW-1:0]       best_id_q [N_TARGET];
    logic [SRCW-1:0]       best_id_d [N_TARGET];
    logic [PRIOW-1:0]      best_prio_q [N_TARGET];
    logic [PRIOW-1:0]      best_prio_d [N_TARGET];
    logic [N_TARGET-1:0]   eip_q, eip_d;
    logic                  rsp_valid_q;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    // Decode and datapath signals
    logic [31:0]         addr;
    logic                unused_addr;
    logic [31:0]         dec_id, dec_w, dec_t;
    logic                hit_prio, hit_pend, hit_ie, hit_thr, hit_claim, dec_err;
    logic                wr, rd;
    logic [NBIT-1:0]     ip;
    logic [N_SOURCE-1:0] rise;
    logic [SRCW-1:0]     claim_val [N_TARGET];
    logic [N_SOURCE:1]   claim_vec, comp_vec;
    logic [31:0]         rdata;

    assign addr        = 32'(req_addr_i);
    assign unused_addr = ^addr[1:0];
    assign wr          = req_valid_i & req_write_i;
    assign rd          = req_valid_i & ~req_write_i;
    assign rise        = irq_sources_i & ~src_q;

    function automatic logic [PRIOW-1:0] clamp_prio(input logic [PRIOW-1:0] raw);
        logic [PRIOW-1:0] v;
        v = raw;
        if (32'(v) > MAX_PRIO) v = PRIOW'(MAX_PRIO);
        return v;
    endfunction

    // Address decode into register class plus id/word/target fields
    always_comb begin
        hit_prio  = 1'b0;
        hit_pend  = 1'b0;
        hit_ie    = 1'b0;
        hit_thr   = 1'b0;
        hit_claim = 1'b0;
        dec_err   = 1'b0;
        dec_id    = {22'd0, addr[11:2]};
        dec_w     = {22'd0, addr[11:2]};
        dec_t     = 32'd0;
        if (addr[31:12] == 20'h0) begin
            if (dec_id <= N_SOURCE) hit_prio = 1'b1;
            else dec_err = 1'b1;
        end else if (addr[31:12] == 20'h1) begin
            if (dec_w < NWORD) hit_pend = 1'b1;
            else dec_err = 1'b1;
        end else if (addr[31:12] == 20'h2) begin
            dec_t = {27'd0, addr[11:7]};
            dec_w = {27'd0, addr[6:2]};
            if (dec_t < N_TARGET && dec_w < NWORD) hit_ie = 1'b1;
            else dec_err = 1'b1;
        end else if (addr[31:17] == 15'h10) begin
            dec_t = {27'd0, addr[16:12]};
            if (dec_t < N_TARGET && addr[11:2] == 10'd0) hit_thr = 1'b1;
            else if (dec_t < N_TARGET && addr[11:2] == 10'd1) hit_claim = 1'b1;
            else dec_err = 1'b1;
        end else begin
            dec_err = 1'b1;
        end
    end

    // Gateway pending: level follows the line, edge follows the counter; both masked in flight
    always_comb begin
        ip = '0;
        for (int unsigned i = 1; i <= N_SOURCE; i++) begin
            ip[i] = (le_i[i-1] ? (cnt_q[i] != '0) : irq_sources_i[i-1]) & ~inflight_q[i];
        end
    end

    // Claim value per target: the registered winner is only handed out if still claimable
    always_comb begin
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            claim_val[t] = '0;
            for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                if (32'(best_id_q[t]) == i && ip[i] && ie_q[t][i]) claim_val[t] = best_id_q[t];
            end
        end
    end

    // Per-target select: strict '>' while scanning upward keeps the lowest ID on ties
    always_comb begin
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            best_prio_d[t] = '0;
            best_id_d[t]   = '0;
            for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                if (ip[i] && ie_q[t][i] && prio_q[i] > best_prio_d[t]) begin
                    best_prio_d[t] = prio_q[i];
                    best_id_d[t]   = SRCW'(i);
                end
            end
            eip_d[t] = best_prio_q[t] > thr_q[t];
        end
    end

    // Register writes, claim and complete side effects
    always_comb begin
        prio_d    = prio_q;
        thr_d     = thr_q;
        ie_d      = ie_q;
        claim_vec = '0;
        comp_vec  = '0;
        if (wr && hit_prio) begin
            for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                if (dec_id == i) prio_d[i] = clamp_prio(req_wdata_i[PRIOW-1:0]);
            end
        end
        if (wr && hit_ie) begin
            for (int unsigned t = 0; t < N_TARGET; t++) begin
                for (int unsigned w = 0; w < NWORD; w++) begin
                    if (dec_t == t && dec_w == w) begin
                        for (int unsigned b = 0; b < 32; b++) begin
                            ie_d[t][w*32+b] = (w*32+b >= 1 && w*32+b <= N_SOURCE) ?
                                              req_wdata_i[b] : 1'b0;
                        end
                    end
                end
            end
        end
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            if (dec_t == t) begin
                if (wr && hit_thr) thr_d[t] = clamp_prio(req_wdata_i[PRIOW-1:0]);
                for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                    if (wr && hit_claim && 32'(req_wdata_i[SRCW-1:0]) == i && ie_q[t][i])
                        comp_vec[i] = 1'b1;
                    if (rd && hit_claim && 32'(claim_val[t]) == i)
                        claim_vec[i] = 1'b1;
                end
            end
        end
    end

    // Edge counters and in-flight flags; an edge coinciding with a claim nets to zero
    always_comb begin
        for (int unsigned i = 1; i <= N_SOURCE; i++) begin
            inflight_d[i] = (inflight_q[i] | claim_vec[i]) & ~comp_vec[i];
            cnt_d[i]      = cnt_q[i];
            if (!le_i[i-1]) begin
                cnt_d[i] = '0;
            end else if (rise[i-1] && !claim_vec[i]) begin
                if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!rise[i-1] && claim_vec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Read mux on current state; errors and writes return zero
    always_comb begin
        rdata = '0;
        if (hit_prio) begin
            for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                if (dec_id == i) rdata = 32'(prio_q[i]);
            end
        end
        for (int unsigned w = 0; w < NWORD; w++) begin
            if (hit_pend && dec_w == w) rdata = ip[w*32 +: 32];
        end
        for (int unsigned t = 0; t < N_TARGET; t++) begin
            if (dec_t == t) begin
                for (int unsigned w = 0; w < NWORD; w++) begin
                    if (hit_ie && dec_w == w) rdata = ie_q[t][w*32 +: 32];
                end
                if (hit_thr)   rdata = 32'(thr_q[t]);
                if (hit_claim) rdata = 32'(claim_val[t]);
            end
        end
        rsp_rdata_d = rd ? rdata : 32'd0;
        rsp_error_d = req_valid_i & dec_err;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i <= N_SOURCE; i++) begin
                prio_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            for (int unsigned t = 0; t < N_TARGET; t++) begin
                ie_q[t]        <= '0;
                thr_q[t]       <= '0;
                best_id_q[t]   <= '0;
                best_prio_q[t] <= '0;
            end
            inflight_q  <= '0;
            src_q       <= '0;
            eip_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            ie_q        <= ie_d;
            thr_q       <= thr_d;
            best_id_q   <= best_id_d;
            best_prio_q <= best_prio_d;
            inflight_q  <= inflight_d;
            src_q       <= irq_sources_i;
            eip_q       <= eip_d;
            rsp_valid_q <= req_valid_i;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign eip_targets_o = eip_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;

endmodule

// File: tb/tb_plic_scalable.sv
// Directed bench for plic_scalable: gateways, arbitration, claim/complete, decode errors.
module tb_plic_scalable;

    localparam logic [23:0] THR0   = 24'h200000;
    localparam logic [23:0] CLAIM0 = 24'h200004;
    localparam logic [23:0] THR1   = 24'h201000;
    localparam logic [23:0] CLAIM1 = 24'h201004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [63:0] le = '0;
    logic [63:0] src = '0;
    logic [1:0]  eip;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        er, vl;

    always #5 clk = ~clk;

    plic_scalable dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .le_i          (le),
        .irq_sources_i (src),
        .eip_targets_o (eip)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request cycle; response captured 1ns after the edge that registers it
    task automatic bus(input logic w, input logic [23:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        rd = rsp_rdata;
        er = rsp_error;
        vl = rsp_valid;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic pulse(input int idx);
        src[idx] = 1'b1;
        tick(1);
        src[idx] = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        tick(3);
        n_cmp++;
        if ({eip, rsp_valid, rsp_error, rsp_rdata} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got eip=%b v=%b e=%b d=%h want all 0",
                     eip, rsp_valid, rsp_error, rsp_rdata);
        end
        rst_n = 1'b1;
        tick(1);
        bus(1'b0, 24'h000014, 32'd0);
        n_cmp++;
        if (vl !== 1'b1 || er !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_prio5 got v=%b e=%b d=%h want 1 0 0", vl, er, rd);
        end
        bus(1'b0, 24'h300000, 32'd0);
        n_cmp++;
        if (vl !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_unmapped got v=%b e=%b d=%h want 1 1 0", vl, er, rd);
        end
    endtask

    task automatic test_level;
        bus(1'b1, 24'h00000C, 32'd2);
        bus(1'b1, 24'h002000, 32'h8);
        bus(1'b1, THR0, 32'd1);
        src[2] = 1'b1;
        tick(1);
        n_cmp++;
        if (eip[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL level_eip_early got %b want 0", eip[0]);
        end
        tick(1);
        n_cmp++;
        if (eip[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL level_eip_2cyc got %b want 1", eip[0]);
        end
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd3) begin
            n_fail++;
            $display("FAIL level_claim got %0d want 3", rd);
        end
        tick(2);
        n_cmp++;
        if (eip[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL level_eip_after_claim got %b want 0", eip[0]);
        end
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL level_second_claim got %0d want 0", rd);
        end
        bus(1'b1, CLAIM0, 32'd3);
        tick(2);
        n_cmp++;
        if (eip[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL level_eip_after_complete got %b want 1", eip[0]);
        end
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd3) begin
            n_fail++;
            $display("FAIL level_reclaim got %0d want 3", rd);
        end
        src[2] = 1'b0;
        tick(1);
        bus(1'b1, CLAIM0, 32'd3);
        tick(2);
        bus(1'b0, 24'h001000, 32'd0);
        n_cmp++;
        if (rd !== 32'd0 || eip[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL level_dropped_inflight got pend=%h eip=%b want 0 0", rd, eip[0]);
        end
    endtask

    task automatic test_edge;
        int got;
        bus(1'b1, 24'h0000A0, 32'd3);
        bus(1'b1, 24'h002004, 32'h100);
        pulse(39);
        tick(2);
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd40) begin
            n_fail++;
            $display("FAIL edge_first_claim got %0d want 40", rd);
        end
        for (int k = 0; k < 3; k++) pulse(39);
        bus(1'b0, 24'h001004, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL edge_pend_inflight got %h want 0", rd);
        end
        bus(1'b1, CLAIM0, 32'd40);
        tick(1);
        bus(1'b0, 24'h001004, 32'd0);
        n_cmp++;
        if (rd !== 32'h100) begin
            n_fail++;
            $display("FAIL edge_pend_after_complete got %h want 00000100", rd);
        end
        for (int r = 0; r < 3; r++) begin
            tick(2);
            bus(1'b0, CLAIM0, 32'd0);
            n_cmp++;
            if (rd !== 32'd40) begin
                n_fail++;
                $display("FAIL edge_round%0d got %0d want 40", r, rd);
            end
            bus(1'b1, CLAIM0, 32'd40);
        end
        tick(2);
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL edge_fourth_claim got %0d want 0", rd);
        end
        for (int k = 0; k < 9; k++) pulse(39);
        tick(2);
        got = 0;
        for (int r = 0; r < 9; r++) begin
            bus(1'b0, CLAIM0, 32'd0);
            n_cmp++;
            if (rd !== ((r < 7) ? 32'd40 : 32'd0)) begin
                n_fail++;
                $display("FAIL edge_sat_round%0d got %0d want %0d", r, rd, (r < 7) ? 40 : 0);
            end
            if (rd == 32'd40) begin
                got++;
                bus(1'b1, CLAIM0, 32'd40);
            end
            tick(2);
        end
        n_cmp++;
        if (got != 7) begin
            n_fail++;
            $display("FAIL edge_sat_total got %0d want 7", got);
        end
        bus(1'b1, 24'h002004, 32'd0);
        bus(1'b1, 24'h0000A0, 32'd0);
    endtask

    task automatic test_arbitration;
        bus(1'b1, 24'h000014, 32'd4);
        bus(1'b1, 24'h00001C, 32'd4);
        bus(1'b1, 24'h002000, 32'hA0);
        src[4] = 1'b1;
        src[6] = 1'b1;
        tick(2);
        bus(1'b0, 24'h001000, 32'd0);
        n_cmp++;
        if (rd !== 32'hA0 || eip[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL arb_pending got pend=%h eip=%b want 000000a0 1", rd, eip[0]);
        end
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd5) begin
            n_fail++;
            $display("FAIL arb_tie got %0d want 5", rd);
        end
        bus(1'b1, CLAIM0, 32'd5);
        bus(1'b1, 24'h00001C, 32'd6);
        tick(2);
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd7) begin
            n_fail++;
            $display("FAIL arb_higher_prio got %0d want 7", rd);
        end
        bus(1'b1, CLAIM0, 32'd7);
        bus(1'b1, THR0, 32'd6);
        tick(2);
        bus(1'b0, 24'h001000, 32'd0);
        n_cmp++;
        if (eip[0] !== 1'b0 || rd !== 32'hA0) begin
            n_fail++;
            $display("FAIL arb_threshold got eip=%b pend=%h want 0 000000a0", eip[0], rd);
        end
        src[4] = 1'b0;
        src[6] = 1'b0;
        bus(1'b1, THR0, 32'd1);
        bus(1'b1, 24'h002000, 32'd0);
    endtask

    task automatic test_two_targets;
        bus(1'b1, 24'h000028, 32'd2);
        bus(1'b1, 24'h002000, 32'h400);
        bus(1'b1, 24'h002080, 32'h400);
        src[9] = 1'b1;
        tick(2);
        n_cmp++;
        if (eip !== 2'b11) begin
            n_fail++;
            $display("FAIL two_eip_both got %b want 11", eip);
        end
        bus(1'b0, CLAIM0, 32'd0);
        n_cmp++;
        if (rd !== 32'd10) begin
            n_fail++;
            $display("FAIL two_t0_claim got %0d want 10", rd);
        end
        bus(1'b0, CLAIM1, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL two_t1_stale_claim got %0d want 0", rd);
        end
        tick(2);
        n_cmp++;
        if (eip !== 2'b00) begin
            n_fail++;
            $display("FAIL two_eip_inflight got %b want 00", eip);
        end
        bus(1'b1, CLAIM1, 32'd10);
        tick(2);
        n_cmp++;
        if (eip !== 2'b11) begin
            n_fail++;
            $display("FAIL two_t1_complete got %b want 11", eip);
        end
        bus(1'b0, CLAIM1, 32'd0);
        n_cmp++;
        if (rd !== 32'd10) begin
            n_fail++;
            $display("FAIL two_t1_claim got %0d want 10", rd);
        end
        bus(1'b1, CLAIM0, 32'd10);
        src[9] = 1'b0;
        tick(2);
        n_cmp++;
        if (eip !== 2'b00) begin
            n_fail++;
            $display("FAIL two_eip_idle got %b want 00", eip);
        end
    endtask

    task automatic test_clamp_ignore;
        bus(1'b1, 24'h000004, 32'hFF);
        bus(1'b0, 24'h000004, 32'd0);
        n_cmp++;
        if (rd !== 32'd7) begin
            n_fail++;
            $display("FAIL clamp_prio1 got %0d want 7", rd);
        end
        bus(1'b1, THR1, 32'hF);
        bus(1'b0, THR1, 32'd0);
        n_cmp++;
        if (rd !== 32'd7) begin
            n_fail++;
            $display("FAIL clamp_thr1 got %0d want 7", rd);
        end
        bus(1'b1, THR1, 32'd0);
        bus(1'b1, 24'h001000, 32'hFFFFFFFF);
        n_cmp++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL ro_write_err got %b want 0", er);
        end
        bus(1'b0, 24'h001000, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL ro_pending got %h want 0", rd);
        end
        bus(1'b1, CLAIM0, 32'd0);
        n_cmp++;
        if (vl !== 1'b1 || er !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL complete_id0 got v=%b e=%b d=%h want 1 0 0", vl, er, rd);
        end
        bus(1'b1, 24'h000000, 32'd5);
        bus(1'b0, 24'h000000, 32'd0);
        n_cmp++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL prio0 got d=%h e=%b want 0 0", rd, er);
        end
        bus(1'b1, 24'h002000, 32'hFFFFFFFF);
        bus(1'b0, 24'h002000, 32'd0);
        n_cmp++;
        if (rd !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL ie_bit0 got %h want fffffffe", rd);
        end
        bus(1'b1, 24'h002008, 32'hFFFFFFFF);
        bus(1'b0, 24'h002008, 32'd0);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL ie_top_word got %h want 00000001", rd);
        end
        bus(1'b1, 24'h002000, 32'd0);
        bus(1'b1, 24'h002008, 32'd0);
    endtask

    task automatic test_errors;
        logic [23:0] bad [7];
        bad = '{24'h000104, 24'h00100C, 24'h002100, 24'h00200C,
                24'h202000, 24'h200008, 24'h003000};
        for (int k = 0; k < 7; k++) begin
            bus(1'b0, bad[k], 32'd0);
            n_cmp++;
            if (vl !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
                n_fail++;
                $display("FAIL decode_err addr=%h got v=%b e=%b d=%h want 1 1 0",
                         bad[k], vl, er, rd);
            end
        end
    endtask

    task automatic test_reset_midop;
        src[9] = 1'b1;
        tick(2);
        n_cmp++;
        if (eip[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_eip_before got %b want 1", eip[1]);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (eip !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_async_drop got %b want 00", eip);
        end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        bus(1'b0, 24'h000028, 32'd0);
        n_cmp++;
        if (rd !== 32'd0) begin
            n_fail++;
            $display("FAIL midop_prio_cleared got %0d want 0", rd);
        end
        src[9] = 1'b0;
    endtask

    initial begin
        le[39] = 1'b1;
        test_reset();
        test_level();
        test_edge();
        test_arbitration();
        test_two_targets();
        test_clamp_ignore();
        test_errors();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
